// File: rtl/mem_pkg.sv
// Shared constants and port-tag encoding for the two-port memory bank arbiter.
package mem_pkg;
  localparam int AW = 11;
  localparam int DW = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // Round-robin: after serving a port, priority passes to the other one.
  function automatic port_t other_port(input port_t served);
    return (served == PORT_A) ? PORT_B : PORT_A;
  endfunction
endpackage

// File: rtl/mem_bank_arbiter_if.sv
// One requesting port of the arbiter: request bus, grant, and read return.
// Handshake: a request (req with we/addr/wdata) is held stable until gnt is 1
// in the same cycle; the transfer happens on that rising edge. rvalid has no
// ready: the port must take rdata in the cycle rvalid is 1.
interface mem_port_if #(
  parameter int AW = 11,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
  modport arb    (input req, output gnt);
endinterface

// File: rtl/mem_bank_arbiter_rr_arb2.sv
// Two-way round-robin grant with a 1-bit priority pointer.
module rr_arb2
  import mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  mem_port_if.arb a,
  mem_port_if.arb b,
  output port_t   ptr
);
  port_t ptr_next;

  always_ff @(posedge clk) begin
    if (rst) ptr <= PORT_A;
    else     ptr <= ptr_next;
  end

  always_comb begin
    a.gnt    = 1'b0;
    b.gnt    = 1'b0;
    ptr_next = ptr;
    if (!rst) begin
      if (a.req && (!b.req || ptr == PORT_A)) a.gnt = 1'b1;
      else if (b.req)                         b.gnt = 1'b1;
    end
    if (a.gnt)      ptr_next = other_port(PORT_A);
    else if (b.gnt) ptr_next = other_port(PORT_B);
  end
endmodule

// File: rtl/mem_bank_arbiter.sv
// Two-port arbiter in front of an external registered memory: grant, one-cycle
// issue stage, and a return stage that routes read data back to its port.
module mem_bank_arbiter #(
  parameter int AW = mem_pkg::AW,
  parameter int DW = mem_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);
  import mem_pkg::*;

  mem_port_if #(.AW(AW), .DW(DW)) a_p ();
  mem_port_if #(.AW(AW), .DW(DW)) b_p ();

  assign a_p.req   = a_req;
  assign a_p.we    = a_we;
  assign a_p.addr  = a_addr;
  assign a_p.wdata = a_wdata;
  assign b_p.req   = b_req;
  assign b_p.we    = b_we;
  assign b_p.addr  = b_addr;
  assign b_p.wdata = b_wdata;
  assign a_gnt     = a_p.gnt;
  assign b_gnt     = b_p.gnt;
  assign a_rvalid  = a_p.rvalid;
  assign a_rdata   = a_p.rdata;
  assign b_rvalid  = b_p.rvalid;
  assign b_rdata   = b_p.rdata;

  port_t arb_ptr;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .a   (a_p.arb),
    .b   (b_p.arb),
    .ptr (arb_ptr)
  );

  logic          gnt_any;
  port_t         gnt_port;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    gnt_any   = a_p.gnt | b_p.gnt;
    gnt_port  = b_p.gnt ? PORT_B : PORT_A;
    sel_we    = b_p.gnt ? b_p.we    : a_p.we;
    sel_addr  = b_p.gnt ? b_p.addr  : a_p.addr;
    sel_wdata = b_p.gnt ? b_p.wdata : a_p.wdata;
  end

  logic          iss_valid;
  logic          iss_we;
  port_t         iss_tag;
  logic [AW-1:0] raddr_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] din_q;
  logic          ret_valid;
  port_t         ret_tag;

  // Address/data registers only load for their own operation so the unused
  // side keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_we    <= 1'b0;
      iss_tag   <= PORT_A;
      raddr_q   <= '0;
      waddr_q   <= '0;
      din_q     <= '0;
      ret_valid <= 1'b0;
      ret_tag   <= PORT_A;
    end else begin
      iss_valid <= gnt_any;
      if (gnt_any) begin
        iss_we  <= sel_we;
        iss_tag <= gnt_port;
        if (sel_we) begin
          waddr_q <= sel_addr;
          din_q   <= sel_wdata;
        end else begin
          raddr_q <= sel_addr;
        end
      end
      ret_valid <= iss_valid & ~iss_we;
      ret_tag   <= iss_tag;
    end
  end

  assign mem_wen   = iss_valid & iss_we;
  assign mem_ren   = iss_valid & ~iss_we;
  assign mem_raddr = raddr_q;
  assign mem_waddr = waddr_q;
  assign mem_din   = din_q;

  // mem_dout arrives the cycle after mem_ren, aligned with ret_valid.
  assign a_p.rvalid = ret_valid && (ret_tag == PORT_A);
  assign b_p.rvalid = ret_valid && (ret_tag == PORT_B);
  assign a_p.rdata  = a_p.rvalid ? mem_dout : '0;
  assign b_p.rdata  = b_p.rvalid ? mem_dout : '0;
endmodule

// File: doc/mem_bank_arbiter.md
MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 11, meaning the byte address width (2048 x 8 multi-bank memory).
REQ-002 The block SHALL have parameter DW, default 8, meaning the data width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The ports SHALL be, in this order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- a_req  in  1  port A request, held until granted
- a_we  in  1  port A op: 1 = write, 0 = read
- a_addr  in  AW  port A address
- a_wdata  in  DW  port A write data
- a_gnt  out  1  port A request accepted this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  DW  port A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_raddr  out  AW  memory read address
- mem_waddr  out  AW  memory write address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data; registered, 1-cycle latency, 0 when no read

Function
REQ-005 The block SHALL grant at most one request per cycle; a_gnt and b_gnt SHALL be combinational and never both 1.
REQ-006 Arbitration SHALL be round-robin through a 1-bit priority pointer:
- only one port requesting: that port is granted
- both ports requesting: the pointed-to port is granted
- after any grant, the pointer moves to the other port
- no grant: the pointer holds
REQ-007 A granted request SHALL be captured into the issue register (valid, we, addr, wdata, tag) at the granting edge.
REQ-008 In the cycle after the grant, the issue register SHALL drive the memory:
- write: mem_wen=1, mem_waddr=addr, mem_din=wdata
- read: mem_ren=1, mem_raddr=addr
REQ-009 mem_ren and mem_wen SHALL never be 1 together.
REQ-010 Address fields of the unused operation SHALL hold their previous values.
REQ-011 For a read, the tag SHALL shift into a return register at the next edge.
REQ-012 Exactly two cycles after a read grant, the tagged port's rvalid SHALL be 1 and its rdata SHALL equal mem_dout.
REQ-013 A non-tagged port, or a port with no read returning, SHALL see rvalid=0 and rdata=0.
REQ-014 Writes SHALL produce no rvalid.
REQ-015 Accepted operations SHALL be issued to memory in grant order, so a write granted at cycle t is visible to a read granted at cycle t+1 or later.
REQ-016 Sustained throughput SHALL be one operation per cycle, with no bubble between back-to-back grants.
REQ-017 Ports SHALL always accept rvalid; the block has no read backpressure.
REQ-018 A request whose req drops before grant SHALL be discarded without side effect.

Reset
REQ-019 On rst=1 at a rising edge, the block SHALL:
- clear the issue and return valid bits
- set the pointer to port A
- drive mem_ren=0, mem_wen=0, mem_raddr=0, mem_waddr=0, mem_din=0
- drive a_rvalid=b_rvalid=0 and a_rdata=b_rdata=0
REQ-020 While rst=1, a_gnt and b_gnt SHALL be 0.
REQ-021 Operations in flight when reset is asserted SHALL be dropped; no rvalid SHALL follow reset.

Structure
REQ-022 AW, DW, and the port-tag encoding (A=0, B=1) SHALL live in shared package mem_pkg.
REQ-023 The round-robin grant logic and the priority pointer SHALL be one sub-module, rr_arb2.
REQ-024 The issue and return stages SHALL be in the top level.
REQ-025 The memory SHALL remain outside the block.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then A writes 0x5A to addr 0x000, then A reads 0x000 -> mem_wen pulses 1 cycle after the write grant; a_rvalid=1 with a_rdata=0x5A 2 cycles after the read grant.
- A and B both request continuously (A reads 0x200, B reads 0x7FF) -> grants alternate A,B,A,B starting with A; rvalid alternates likewise with no idle cycle.
- A writes 0x33 to 0x4C1 at cycle t, B reads 0x4C1 from cycle t -> B is granted at t+1 and b_rdata=0x33 at t+3.
- Bank and subbank boundaries: write and readback at 0x07F, 0x080, 0x1FF, 0x200, 0x7FF -> each readback returns its own written value; no aliasing.
- rst asserted in the cycle after a read grant -> no rvalid on either port, all memory outputs 0, next grant goes to A.
- A raises req then drops it the cycle B is granted -> no A operation reaches memory.
